smac_bitserial_ctrl: RTL and testbench
======================================

Name: smac_bitserial_ctrl

Overview:
Sequencer for the bit-serial weight path of the SMAC dot-product engine. Accepts one job per start handshake and walks the weight bits LSB-first. Drives the sign-correction stage's enable and weight-MSB flag, then the downstream shift-accumulator's clear, enable and shift amount. Presents a result-valid handshake once the final negated partial sum has been accumulated. Sits between the job dispatcher and the DP_1x64 datapath.

Parameters:
PW, 8, maximum weight precision in bits (two's complement); must be >= 2
BW, $clog2(PW)+1, width of precision and bit-index fields (localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start_valid  in  1  job request
start_ready  out  1  controller can accept a job (high only in IDLE)
cfg_bits  in  BW  weight precision for this job; sampled on start handshake
w_en  out  1  enable to the sign-correction stage
msb_w  out  1  current bit is the weight sign bit; only meaningful with w_en
bit_idx  out  BW  index of the weight bit currently presented
acc_clr  out  1  accumulator loads rather than adds; asserted with the first acc_en
acc_en  out  1  accumulator update, one cycle after w_en
acc_shamt  out  BW  shift applied to the sign-corrected sum (bit_idx delayed by 1)
out_valid  out  1  accumulated result ready
out_ready  in  1  consumer accepts result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except start_ready=1; internal counters 0; latched precision N=PW.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start_ready=1. On start_valid, latch N and go to RUN. Latching rules:
  - cfg_bits==0 latches N=PW.
  - cfg_bits>PW clamps to N=PW.
  - cfg_bits==1 is legal; that single bit is also the MSB.
- RUN: w_en=1 every cycle. bit_idx counts 0..N-1. msb_w=1 only when bit_idx==N-1. After the bit_idx==N-1 cycle, go to DRAIN.
- DRAIN: exactly one cycle. w_en=0. Covers the sign-correction stage's one-cycle register latency.
- acc_en = w_en delayed by one register. acc_shamt = bit_idx delayed by one. acc_clr = 1 only on the acc_en cycle with acc_shamt==0.
- DONE: out_valid=1, held until out_valid&out_ready, then go to IDLE. Sampled cfg_bits and all datapath controls stay 0 while in DONE.
- Latency: handshake at cycle T; w_en on T+1..T+N; acc_en on T+2..T+N+1; out_valid from T+N+2. Next start is accepted no earlier than the cycle after the out handshake.
- start_valid outside IDLE is ignored and not queued.
- out_ready outside DONE has no effect.
- Reset asserted mid-job aborts the job. No partial result is flagged. The accumulator is not cleared by this block; the next job's acc_clr handles it.
- All outputs are registered (no combinational path from inputs to outputs), except start_ready, which decodes state only.

Optional Feature:
SMAC_CTRL_PERF_EN
- Defined: adds output perf_jobs [31:0], incremented on each out handshake and wrapping at 2^32-1 to 0.
- Defined: adds output perf_stall [31:0], incremented each cycle with out_valid&!out_ready, saturating at 2^32-1.
- Defined: both counters reset to 0 on rst.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package smac_ctrl_pkg holds:
  - state enum ctrl_state_e {IDLE, RUN, DRAIN, DONE}
  - PW default constant
  - clamp function for cfg_bits
- One sub-module, smac_bit_cnt. It is a loadable up-counter with terminal flag, instantiated for bit_idx.

Test Plan:
- PW=8, cfg_bits=8, out_ready=1 → w_en on 8 consecutive cycles, msb_w only on bit_idx=7; acc_en on cycles T+2..T+9; acc_clr only at T+2; out_valid at T+10 for 1 cycle.
- cfg_bits=0 and cfg_bits=12 (PW=8) → both run 8 bits, identical to the 8-bit case. cfg_bits=1 → one w_en cycle with msb_w=1 and bit_idx=0; out_valid at T+3.
- out_ready held 0 for 5 cycles in DONE → out_valid stays 1 and start_ready stays 0; start_valid pulses are ignored; IDLE on the cycle after out_ready=1.
- rst pulsed while bit_idx=3 → outputs 0 and start_ready=1 asynchronously; a new job then starts with bit_idx=0 and acc_clr=1.
- Back-to-back jobs with start_valid held high → second handshake occurs the cycle after the first out handshake; acc_shamt sequence restarts at 0.
- With SMAC_CTRL_PERF_EN defined, 3 jobs with 4 total stall cycles → perf_jobs=3, perf_stall=4. With the macro undefined, the bench compiles without the perf ports.

Source files
------------

// File: rtl/smac_ctrl_pkg.sv
// smac_ctrl_pkg
// Shared types and helpers for the SMAC bit-serial weight-path controller.
//   ctrl_state_e : controller state encoding
//   PW_DEF       : default maximum weight precision
//   clamp_bits() : maps a requested precision onto the legal range 1..pw
package smac_ctrl_pkg;

  localparam int PW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_e;

  // Zero means "full precision"; anything above the hardware limit is
  // clamped to the limit.
  function automatic int unsigned clamp_bits(input int unsigned cfg,
                                             input int unsigned pw);
    if (cfg == 0 || cfg > pw) return pw;
    return cfg;
  endfunction

endpackage

// File: rtl/smac_bit_cnt.sv
// smac_bit_cnt
// Loadable up-counter with terminal-count flag, used to walk weight bits.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over en)
//   load_val  : value loaded on load
//   en        : increment by one
//   last      : terminal value
//   q         : current count
//   tc        : q == last
module smac_bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

  assign tc = (q == last);

endmodule

// File: rtl/smac_bitserial_ctrl.sv
// smac_bitserial_ctrl
// Sequencer for the bit-serial weight path of the SMAC dot-product engine.
// Accepts one job per start handshake, walks weight bits LSB-first, drives
// the sign-correction stage (w_en/msb_w/bit_idx), then the shift-accumulator
// (acc_en/acc_clr/acc_shamt) one cycle later, and finally presents out_valid.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   start_valid/start_ready : job handshake; cfg_bits sampled on handshake
//   w_en, msb_w, bit_idx    : sign-correction stage controls
//   acc_clr, acc_en,
//   acc_shamt               : shift-accumulator controls
//   out_valid/out_ready     : result handshake
//   busy                    : controller not idle
//   perf_jobs, perf_stall   : performance counters (SMAC_CTRL_PERF_EN only)
// Optional build macro: SMAC_CTRL_PERF_EN
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a job, start_ready high
// RUN   | presenting weight bits 0..N-1, one per cycle
// DRAIN | one cycle covering the sign-correction register latency
// DONE  | out_valid held until the consumer takes the result
module smac_bitserial_ctrl
  import smac_ctrl_pkg::*;
#(
  parameter  int PW = PW_DEF,
  localparam int BW = $clog2(PW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [BW-1:0] cfg_bits,
  output logic          w_en,
  output logic          msb_w,
  output logic [BW-1:0] bit_idx,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [BW-1:0] acc_shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
`ifdef SMAC_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_jobs,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [BW-1:0] ONE = BW'(1);

  ctrl_state_e   state, state_nxt;
  logic [BW-1:0] n_lat, n_nxt, n_start, n_last;
  logic          cnt_load, cnt_en, cnt_tc;
  logic          w_en_nxt, msb_nxt, out_valid_nxt;

  assign n_start = BW'(clamp_bits(32'(cfg_bits), 32'(PW)));
  assign n_last  = n_lat - ONE;

  smac_bit_cnt #(.W(BW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .last     (n_last),
    .q        (bit_idx),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The counter is reloaded to 0 both on start and when RUN ends, so
  // bit_idx reads 0 whenever the sign-correction stage is idle.
  always_comb begin
    state_nxt     = state;
    n_nxt         = n_lat;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    w_en_nxt      = 1'b0;
    msb_nxt       = 1'b0;
    out_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid) begin
          state_nxt = RUN;
          n_nxt     = n_start;
          cnt_load  = 1'b1;
          w_en_nxt  = 1'b1;
          msb_nxt   = (n_start == ONE);
        end
      end
      RUN: begin
        if (cnt_tc) begin
          state_nxt = DRAIN;
          cnt_load  = 1'b1;
        end else begin
          cnt_en   = 1'b1;
          w_en_nxt = 1'b1;
          msb_nxt  = ((bit_idx + ONE) == n_last);
        end
      end
      DRAIN: begin
        state_nxt     = DONE;
        out_valid_nxt = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          out_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accumulator controls trail the sign-correction controls by one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat     <= BW'(PW);
      w_en      <= 1'b0;
      msb_w     <= 1'b0;
      acc_en    <= 1'b0;
      acc_clr   <= 1'b0;
      acc_shamt <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      n_lat     <= n_nxt;
      w_en      <= w_en_nxt;
      msb_w     <= msb_nxt;
      acc_en    <= w_en;
      acc_clr   <= w_en && (bit_idx == '0);
      acc_shamt <= w_en ? bit_idx : '0;
      out_valid <= out_valid_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  assign start_ready = (state == IDLE);

`ifdef SMAC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jobs  <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready) begin
        perf_jobs <= perf_jobs + 32'd1;
      end
      if (out_valid && !out_ready && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_smac_bitserial_ctrl.sv
// tb_smac_bitserial_ctrl
// Self-checking bench for smac_bitserial_ctrl. Per-cycle expected control
// vectors are queued when a job is launched and popped each cycle.
// Optional build macro: SMAC_CTRL_PERF_EN (enables perf counter checks).
module tb_smac_bitserial_ctrl;

  localparam int PW = 8;
  localparam int BW = $clog2(PW) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] cfg_bits = '0;
  logic          start_ready, w_en, msb_w, acc_clr, acc_en, out_valid, busy;
  logic [BW-1:0] bit_idx, acc_shamt;
`ifdef SMAC_CTRL_PERF_EN
  logic [31:0]   perf_jobs, perf_stall;
`endif

  smac_bitserial_ctrl #(.PW(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .cfg_bits    (cfg_bits),
    .w_en        (w_en),
    .msb_w       (msb_w),
    .bit_idx     (bit_idx),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .acc_shamt   (acc_shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
`ifdef SMAC_CTRL_PERF_EN
    ,
    .perf_jobs   (perf_jobs),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          w_en;
    logic          msb_w;
    logic [BW-1:0] bit_idx;
    logic          acc_en;
    logic          acc_clr;
    logic [BW-1:0] acc_shamt;
    logic          out_valid;
    logic          start_ready;
    logic          busy;
  } vec_t;

  typedef struct {
    vec_t v;
    logic sv;
    logic orr;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  vec_t obs;

  assign obs = {w_en, msb_w, bit_idx, acc_en, acc_clr, acc_shamt,
                out_valid, start_ready, busy};

  // Expected outputs k cycles after the start handshake for an n-bit job.
  function automatic vec_t model(input int n, input int k);
    vec_t v;
    v      = '0;
    v.busy = 1'b1;
    if (k >= 1 && k <= n) begin
      v.w_en    = 1'b1;
      v.bit_idx = BW'(k - 1);
      v.msb_w   = (k == n);
    end
    if (k >= 2 && k <= n + 1) begin
      v.acc_en    = 1'b1;
      v.acc_shamt = BW'(k - 2);
      v.acc_clr   = (k == 2);
    end
    if (k >= n + 2) v.out_valid = 1'b1;
    return v;
  endfunction

  function automatic vec_t idle_vec();
    vec_t v;
    v             = '0;
    v.start_ready = 1'b1;
    return v;
  endfunction

  // Called at a negedge with the DUT idle. Launches one job and checks every
  // cycle through the return to IDLE. stall = DONE cycles with out_ready low
  // (start_valid is pulsed during those to confirm it is ignored); hold keeps
  // start_valid high throughout so the next job starts immediately.
  task automatic run_job(input string name, input logic [BW-1:0] cfg,
                         input int n, input int stall, input logic hold);
    rec_t r;
    int   k;
    total++;
    if (start_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s start_ready got=%b want=1", name, start_ready);
    end
    start_valid = 1'b1;
    cfg_bits    = cfg;
    for (int i = 1; i <= n + 1; i++) begin
      r.v   = model(n, i);
      r.sv  = hold;
      r.orr = 1'b1;
      sb.push_back(r);
    end
    for (int d = 0; d <= stall; d++) begin
      r.v   = model(n, n + 2);
      r.sv  = hold ? 1'b1 : ((d < stall) ? d[0] : 1'b0);
      r.orr = (d == stall);
      sb.push_back(r);
    end
    r.v   = idle_vec();
    r.sv  = hold;
    r.orr = 1'b0;
    sb.push_back(r);
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      k++;
      r = sb.pop_front();
      total++;
      if (obs !== r.v) begin
        bad++;
        $display("FAIL %s cycle=T+%0d got=%h want=%h", name, k, obs, r.v);
      end
      start_valid = r.sv;
      out_ready   = r.orr;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (obs !== idle_vec()) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", obs, idle_vec());
    end
`ifdef SMAC_CTRL_PERF_EN
    total++;
    if (perf_jobs !== 32'd0 || perf_stall !== 32'd0) begin
      bad++;
      $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_jobs, perf_stall);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_prec();
    run_job("full8", BW'(8), 8, 0, 1'b0);
    run_job("prec3", BW'(3), 3, 0, 1'b0);
  endtask

  task automatic test_clamp();
    run_job("cfg0", BW'(0), 8, 0, 1'b0);
    run_job("cfg12", BW'(12), 8, 0, 1'b0);
    run_job("cfg15", BW'(15), 8, 0, 1'b0);
    run_job("cfg1", BW'(1), 1, 0, 1'b0);
    run_job("cfg2", BW'(2), 2, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_job("stall5", BW'(8), 8, 5, 1'b0);
  endtask

  task automatic test_abort();
    vec_t want;
    start_valid = 1'b1;
    cfg_bits    = BW'(8);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    want = model(8, 4);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL abort_pre got=%h want=%h", obs, want);
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== idle_vec()) begin
      bad++;
      $display("FAIL abort_async got=%h want=%h", obs, idle_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    run_job("after_abort", BW'(8), 8, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", BW'(8), 8, 0, 1'b1);
    run_job("b2b_b", BW'(4), 4, 0, 1'b1);
    run_job("b2b_c", BW'(1), 1, 0, 1'b0);
  endtask

`ifdef SMAC_CTRL_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_job("perf_a", BW'(8), 8, 1, 1'b0);
    run_job("perf_b", BW'(2), 2, 3, 1'b0);
    run_job("perf_c", BW'(5), 5, 0, 1'b0);
    total++;
    if (perf_jobs !== 32'd3) begin
      bad++;
      $display("FAIL perf_jobs got=%0d want=3", perf_jobs);
    end
    total++;
    if (perf_stall !== 32'd4) begin
      bad++;
      $display("FAIL perf_stall got=%0d want=4", perf_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_prec();
    test_clamp();
    test_stall();
    test_abort();
    test_back_to_back();
`ifdef SMAC_CTRL_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
